addsub_arbiter: RTL

//   Shares one matrix add/sub unit (4x4 x 16-bit matrices, packed 256-bit) between NUM_REQ requesters.
//   - Round-robin arbitration of requests.
//   - Latches the winner's operands and drives the unit's enable/select for exactly one clock.
//   - Captures the registered result and returns it with a one-cycle done pulse.
//   - Sits between the instruction-decode/matrix-op issuers and the add/sub datapath.

---
 rtl/addsub_arbiter_if.sv | 34 +++
 rtl/addsub_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/addsub_arbiter_if.sv
// Bundle between the matrix-op issuers, the add/sub datapath and addsub_arbiter.
// The arbiter uses the slave modport; issuers and the datapath sit on the master side.
interface addsub_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int MW      = 256,
   parameter int CNT_W   = 16
);
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    op_sub;
   logic [NUM_REQ*MW-1:0] a_in;
   logic [NUM_REQ*MW-1:0] b_in;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    done;
   logic [MW-1:0]         result;
   logic                  busy;
   logic [CNT_W-1:0]      op_count;
   logic [MW-1:0]         au_m1;
   logic [MW-1:0]         au_m2;
   logic                  au_select_op;
   logic                  au_enable;
   logic [MW-1:0]         au_result;

   modport slave (
      input  req, op_sub, a_in, b_in, au_result,
      output grant, done, result, busy, op_count,
             au_m1, au_m2, au_select_op, au_enable
   );

   modport master (
      output req, op_sub, a_in, b_in, au_result,
      input  grant, done, result, busy, op_count,
             au_m1, au_m2, au_select_op, au_enable
   );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 4x4x16 matrix add/sub unit between NUM_REQ issuers.
// Issues one op at a time, captures the unit's registered result and pulses done to the owner.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | no op in flight; pick next requester round-robin
//   S_ISSUE   | operands/select driven, au_enable high for this cycle only
//   S_CAPTURE | datapath result valid on au_result
//   S_RESP    | result held, done pulse to owner
module addsub_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int MW      = 256,
   parameter int CNT_W   = 16
) (
   input  logic            clk,
   input  logic            reset,
   addsub_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t               state_q,    state_d;
   logic [PTR_W-1:0]     ptr_q,      ptr_d;
   logic [NUM_REQ-1:0]   grant_q,    grant_d;
   logic [NUM_REQ-1:0]   done_q,     done_d;
   logic [MW-1:0]        result_q,   result_d;
   logic [MW-1:0]        au_m1_q,    au_m1_d;
   logic [MW-1:0]        au_m2_q,    au_m2_d;
   logic                 au_sel_q,   au_sel_d;
   logic                 au_en_q,    au_en_d;
   logic [CNT_W-1:0]     op_count_q, op_count_d;

   logic [PTR_W-1:0]     win_idx;
   logic                 win_found;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      done_d     = done_q;
      result_d   = result_q;
      au_m1_d    = au_m1_q;
      au_m2_d    = au_m2_q;
      au_sel_d   = au_sel_q;
      au_en_d    = au_en_q;
      op_count_d = op_count_q;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_d  = NUM_REQ'(1) << win_idx;
               ptr_d    = win_idx;
               au_m1_d  = bus.a_in[int'(win_idx)*MW +: MW];
               au_m2_d  = bus.b_in[int'(win_idx)*MW +: MW];
               au_sel_d = bus.op_sub[win_idx];
               au_en_d  = 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            au_en_d = 1'b0;
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // au_result is only driven by the unit in this cycle.
            result_d   = bus.au_result;
            done_d     = grant_q;
            op_count_d = op_count_q + CNT_W'(1);
            state_d    = S_RESP;
         end
         S_RESP: begin
            done_d  = '0;
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= PTR_W'(NUM_REQ - 1);
         grant_q    <= '0;
         done_q     <= '0;
         result_q   <= '0;
         au_m1_q    <= '0;
         au_m2_q    <= '0;
         au_sel_q   <= 1'b0;
         au_en_q    <= 1'b0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         result_q   <= result_d;
         au_m1_q    <= au_m1_d;
         au_m2_q    <= au_m2_d;
         au_sel_q   <= au_sel_d;
         au_en_q    <= au_en_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.done         = done_q;
   assign bus.result       = result_q;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.op_count     = op_count_q;
   assign bus.au_m1        = au_m1_q;
   assign bus.au_m2        = au_m2_q;
   assign bus.au_select_op = au_sel_q;
   assign bus.au_enable    = au_en_q;

endmodule
